// File: rtl/gelato_types.sv
// Shared Gelato frontend types.
//   inst_t        : raw 32-bit instruction word
//   warp_state_t  : per-warp fetch lifecycle state
//   fetch_req_t   : fetch request bundle (warp index + PC) for the default
//                   frontend configuration
//   warp_is_ready : helper used to build arbiter request vectors
package gelato_types;

    localparam int GELATO_PC_W   = 32;
    localparam int GELATO_WARP_W = 2;

    typedef logic [31:0] inst_t;

    typedef enum logic [1:0] {
        WS_INACTIVE = 2'd0,
        WS_READY    = 2'd1,
        WS_WAIT     = 2'd2,
        WS_STALLED  = 2'd3
    } warp_state_t;

    typedef struct packed {
        logic                     valid;
        logic [GELATO_WARP_W-1:0] warp;
        logic [GELATO_PC_W-1:0]   pc;
    } fetch_req_t;

    function automatic logic warp_is_ready(input warp_state_t s);
        return s == WS_READY;
    endfunction

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans req starting at ptr+1 (wrapping modulo N) and picks the first set bit.
// Ports:
//   req       in  N  request vector
//   ptr       in  W  index of the last winner; it has lowest priority
//   grant     out N  one-hot grant
//   grant_idx out W  index of the granted requester (0 when none)
//   any       out 1  at least one request present
module gelato_rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         any
);

    always_comb begin
        logic [W-1:0] cand;
        cand      = '0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        // i == N wraps back onto ptr itself, so the last winner is tried last.
        for (int i = 1; i <= N; i++) begin
            cand = W'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/gelato_warp_scheduler.sv
// Per-warp fetch scheduler for the Gelato frontend.
// Tracks a lifecycle state and PC per warp, grants one READY warp per cycle to
// I-Fetch in round-robin order, and parks it until decode reports the next PC
// or a stall; stalled warps wait for execute to resume them.
//
// Per-warp state machine:
//   state       | meaning
//   ------------+-------------------------------------------------------
//   WS_INACTIVE | warp not running; only a launch moves it
//   WS_READY    | has a valid PC, eligible for a fetch grant
//   WS_WAIT     | fetch issued, waiting for decode to report next PC/stall
//   WS_STALLED  | branch/AUIPC pending, waiting for execute to resume it
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   rdy                                 global enable; low freezes everything
//   launch_valid/launch_warp/launch_pc  start a warp at a PC
//   exit_valid/exit_warp                retire a warp (never an error)
//   fetch_ready                         I-Fetch can accept a request
//   fetch_valid/fetch_warp_num/fetch_pc registered one-cycle fetch request
//   upd_valid/upd_warp/upd_stall/upd_pc decode-side next-PC or stall report
//   resume_valid/resume_warp/resume_pc  execute-side branch resolution
//   idle                                all warps inactive (combinational)
//   err                                 one-cycle pulse on an illegal event
module gelato_warp_scheduler
    import gelato_types::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int PC_WIDTH  = 32,
    parameter int WARP_W    = $clog2(NUM_WARPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                launch_valid,
    input  logic [WARP_W-1:0]   launch_warp,
    input  logic [PC_WIDTH-1:0] launch_pc,
    input  logic                exit_valid,
    input  logic [WARP_W-1:0]   exit_warp,
    input  logic                fetch_ready,
    output logic                fetch_valid,
    output logic [WARP_W-1:0]   fetch_warp_num,
    output logic [PC_WIDTH-1:0] fetch_pc,
    input  logic                upd_valid,
    input  logic [WARP_W-1:0]   upd_warp,
    input  logic                upd_stall,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic                resume_valid,
    input  logic [WARP_W-1:0]   resume_warp,
    input  logic [PC_WIDTH-1:0] resume_pc,
    output logic                idle,
    output logic                err
);

    warp_state_t         state_q [NUM_WARPS];
    warp_state_t         state_d [NUM_WARPS];
    logic [PC_WIDTH-1:0] pc_q    [NUM_WARPS];
    logic [PC_WIDTH-1:0] pc_d    [NUM_WARPS];
    logic [WARP_W-1:0]   rr_ptr_q;

    logic [NUM_WARPS-1:0] ready_vec;
    logic [NUM_WARPS-1:0] grant_oh;
    logic [WARP_W-1:0]    grant_idx;
    logic                 grant_any;
    logic                 grant_fire;
    logic                 err_d;

    // Eligibility is taken from the registered state, so a warp that becomes
    // READY this cycle is only considered on the next one.
    always_comb begin
        ready_vec = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            ready_vec[w] = warp_is_ready(state_q[w]);
        end
    end

    gelato_rr_arbiter #(
        .N (NUM_WARPS),
        .W (WARP_W)
    ) u_arb (
        .req       (ready_vec),
        .ptr       (rr_ptr_q),
        .grant     (grant_oh),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign grant_fire = fetch_ready && grant_any;

    // Next state per warp. Legal launch/update/resume events are mutually
    // exclusive by current state, so their order below only matters for err.
    // Exit is applied last and overrides everything; an event that loses to
    // an exit on the same warp is dropped silently rather than flagged.
    always_comb begin
        logic exiting;
        exiting = 1'b0;
        err_d   = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            state_d[w] = state_q[w];
            pc_d[w]    = pc_q[w];
            exiting    = exit_valid && (exit_warp == WARP_W'(w));

            if (grant_fire && grant_oh[w]) begin
                state_d[w] = WS_WAIT;
            end

            if (launch_valid && (launch_warp == WARP_W'(w))) begin
                if (state_q[w] == WS_INACTIVE) begin
                    state_d[w] = WS_READY;
                    pc_d[w]    = launch_pc;
                end else if (!exiting) begin
                    err_d = 1'b1;
                end
            end

            if (upd_valid && (upd_warp == WARP_W'(w))) begin
                if (state_q[w] == WS_WAIT) begin
                    if (upd_stall) begin
                        state_d[w] = WS_STALLED;
                    end else begin
                        state_d[w] = WS_READY;
                        pc_d[w]    = upd_pc;
                    end
                end else if (!exiting) begin
                    err_d = 1'b1;
                end
            end

            if (resume_valid && (resume_warp == WARP_W'(w))) begin
                if (state_q[w] == WS_STALLED) begin
                    state_d[w] = WS_READY;
                    pc_d[w]    = resume_pc;
                end else if (!exiting) begin
                    err_d = 1'b1;
                end
            end

            if (exiting) begin
                state_d[w] = WS_INACTIVE;
            end
        end
    end

    always_comb begin
        idle = 1'b1;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (state_q[w] != WS_INACTIVE) begin
                idle = 1'b0;
            end
        end
    end

    // rr_ptr resets to the last index so warp 0 has top priority first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= WS_INACTIVE;
                pc_q[w]    <= '0;
            end
            rr_ptr_q       <= WARP_W'(NUM_WARPS - 1);
            fetch_valid    <= 1'b0;
            fetch_warp_num <= '0;
            fetch_pc       <= '0;
            err            <= 1'b0;
        end else if (rdy) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= state_d[w];
                pc_q[w]    <= pc_d[w];
            end
            fetch_valid <= grant_fire;
            if (grant_fire) begin
                fetch_warp_num <= grant_idx;
                fetch_pc       <= pc_q[grant_idx];
                rr_ptr_q       <= grant_idx;
            end
            err <= err_d;
        end
    end

endmodule

// File: doc/gelato_warp_scheduler.md
# gelato_warp_scheduler

Per-warp fetch scheduler for the Gelato frontend. It tracks a lifecycle state and PC for every warp and picks one ready warp per cycle in round-robin order to send to I-Fetch. It then parks that warp until I-Decode reports the next PC or a stall. Stalled warps (branch, AUIPC) stay parked until the execute stage resumes them with a resolved PC.

## Interface
Parameters:
- NUM_WARPS, 4, number of hardware warps (power of two, ≥2)
- PC_WIDTH, 32, PC width
- WARP_W, $clog2(NUM_WARPS), warp index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; low freezes all state and outputs
- launch_valid / launch_warp / launch_pc  in  1 / WARP_W / PC_WIDTH  start a warp at a PC
- exit_valid / exit_warp  in  1 / WARP_W  retire a warp
- fetch_ready  in  1  I-Fetch can accept a request this cycle
- fetch_valid / fetch_warp_num / fetch_pc  out  1 / WARP_W / PC_WIDTH  fetch request
- upd_valid / upd_warp / upd_stall / upd_pc  in  1 / WARP_W / 1 / PC_WIDTH  decode-side split-table update
- resume_valid / resume_warp / resume_pc  in  1 / WARP_W / PC_WIDTH  execute-side branch resolution
- idle  out  1  all warps INACTIVE
- err  out  1  one-cycle pulse on an illegal event

## Operation
- Per-warp state is INACTIVE, READY, WAIT or STALLED, with a per-warp PC register.
- Launch: INACTIVE → READY and pc := launch_pc. If the warp is not INACTIVE, the launch is ignored and err pulses.
- Grant: in a cycle with rdy && fetch_ready && at least one READY warp, select the first READY warp scanning from rr_ptr+1 with modulo NUM_WARPS wrap.
  - Register fetch_warp_num and fetch_pc from the selected warp.
  - Set the warp to WAIT and set rr_ptr to the granted index.
- Update (upd_valid): the warp must be in WAIT.
  - upd_stall=1: WAIT → STALLED, pc unchanged.
  - upd_stall=0: WAIT → READY, pc := upd_pc.
  - Any other state: ignored, err pulses.
- Resume: STALLED → READY and pc := resume_pc. Any other state: ignored, err pulses.
- Exit: any state → INACTIVE. An exit is never an error.
- Same-warp same-cycle priority: exit > update/resume > launch > grant.
  - Grant eligibility uses the state at the start of the cycle, so a warp made READY this cycle is not granted until the next cycle.
  - A warp that is granted and exited in the same cycle still gets its fetch_valid pulse. Any later update for that warp raises err.
- At most one fetch is in flight per warp; a warp in WAIT or STALLED is never granted.
- idle = AND over all warps of (state == INACTIVE); it is combinational from the state registers.

## Timing
- Reset values: all states INACTIVE, all PCs 0, rr_ptr = NUM_WARPS-1 (so warp 0 wins first), fetch_valid 0, fetch_warp_num 0, fetch_pc 0, err 0, idle 1.
- fetch_valid is a registered one-cycle pulse in the cycle after a grant. It is not held; I-Fetch must take the request when it sees fetch_valid.
- Back-to-back grants to different warps are allowed every cycle.
- Launch latency: launch at edge N → warp READY after N → grant at edge N+1 → fetch_valid high during cycle N+1..N+2.
- Update-to-regrant: 1 cycle of READY then the grant edge, giving a minimum fetch-to-fetch loop per warp equal to decode latency + 2.
- rdy low: no state changes, fetch_valid and err are held at their current values, and inputs are ignored.
- Asynchronous reset mid-operation drops all in-flight bookkeeping immediately. Late updates arriving after reset raise err.

## Structure
- The warp state enum (warp_state_t) and a fetch-request struct belong in gelato_types, next to inst_t.
- Sub-module gelato_rr_arbiter (parameter N): inputs req[N] and ptr; outputs grant one-hot, grant index and any. It is purely combinational and reusable by the issue stage.
- All sequential logic lives in gelato_warp_scheduler: a per-warp state/PC array and an always_ff block on (posedge clk, negedge rst_n).

## Test plan
- Reset, then launch warp 0 at 0x100 with fetch_ready=1 → fetch_valid with warp 0 and pc 0x100 two cycles later; idle goes 1→0.
- Launch warps 0-3 at 0x0/0x40/0x80/0xC0 in the same cycle window with fetch_ready held 1 → grants in order 0,1,2,3, one per cycle, with no repeats until updates arrive.
- Warp 1 in WAIT receives upd_stall=0 with upd_pc=0x44 → regranted with pc 0x44. Warp 2 receives upd_stall=1 → never granted until resume_pc=0x200, then fetched at 0x200.
- Update to warp 3 while STALLED, or launch of an already-active warp → single-cycle err pulse with no state or PC change.
- Exit and resume of warp 2 in the same cycle → warp 2 is INACTIVE and never granted. Hold fetch_ready=0 for 5 cycles → no fetch_valid pulse in that window.
- Assert rdy=0 while warps are READY → outputs frozen. Assert rst_n low mid-stream → all outputs return to their reset values asynchronously.
